// File: rtl/gb_lcd_capture_if.sv
// LCD pin sample bus and framebuffer write port of gb_lcd_capture.
// With GBCAP_DOUBLE_BUF_EN defined, fb_addr carries one extra MSB (write bank).
interface gb_lcd_capture_if #(
  parameter int PIX_BITS = 2,
  parameter int ADDR_W   = 15
);
`ifdef GBCAP_DOUBLE_BUF_EN
  localparam int FB_AW = ADDR_W + 1;
`else
  localparam int FB_AW = ADDR_W;
`endif

  logic                hs;
  logic                vs;
  logic                px_en;
  logic [PIX_BITS-1:0] d;
  logic [FB_AW-1:0]    fb_addr;
  logic [PIX_BITS-1:0] fb_data;
  logic                fb_we;

  // Handshake: px_en and fb_we are valid-only strobes with no ready. Every px_en
  // sample is consumed in the cycle it is seen, and the framebuffer must take
  // every fb_we write in the cycle it is presented.
  modport master (output hs, vs, px_en, d, input fb_addr, fb_data, fb_we);
  modport slave  (input hs, vs, px_en, d, output fb_addr, fb_data, fb_we);
endinterface

// File: rtl/gb_lcd_capture.sv
// DMG LCD capture: hsync/vsync/pixel samples -> linear framebuffer writes.
// Optional GBCAP_DOUBLE_BUF_EN adds a write-bank MSB and a completed-bank output.
module gb_lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int PIX_BITS = 2,
  parameter int ADDR_W   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  gb_lcd_capture_if.slave      bus,
  input  logic                 clr_err,
  output logic                 frame_done,
  output logic                 rd_bank,
  output logic [7:0]           line_idx,
  output logic [7:0]           frame_cnt,
  output logic                 err_short_line,
  output logic                 err_long_line,
  output logic                 err_short_frame,
  output logic [1:0]           dbg_state
);
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam logic [XW-1:0]     X_END  = XW'(H_PIXELS);
  localparam logic [XW-1:0]     X_LAST = XW'(H_PIXELS - 1);
  localparam logic [7:0]        L_END  = 8'(V_LINES);
  localparam logic [7:0]        L_LAST = 8'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              hs_q, vs_q, hs_edge, vs_edge;
  logic [XW-1:0]     x;
  logic [7:0]        line;
  logic [ADDR_W-1:0] base, pix_addr;
  logic              restart, new_line, accept, long_px;
  logic              short_line_evt, short_frame_evt;

  assign hs_edge   = bus.hs & ~hs_q;
  assign vs_edge   = bus.vs & ~vs_q;
  assign pix_addr  = base + ADDR_W'(x);
  assign line_idx  = line;
  assign frame_done = (state == DONE);
  assign dbg_state = state;

  // Edge history follows the pins even through reset so a level held high
  // across reset is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    hs_q <= bus.hs;
    vs_q <= bus.vs;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d         = state;
    restart         = 1'b0;
    new_line        = 1'b0;
    accept          = 1'b0;
    long_px         = 1'b0;
    short_line_evt  = 1'b0;
    short_frame_evt = 1'b0;
    case (state)
      IDLE: begin
        if (vs_edge) begin
          restart = 1'b1;
          state_d = hs_edge ? ACTIVE : ARMED;
        end
      end
      ARMED: begin
        if (vs_edge) begin
          short_frame_evt = 1'b1;
          restart         = 1'b1;
          state_d         = hs_edge ? ACTIVE : ARMED;
        end else if (hs_edge) begin
          restart = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // vs outranks hs, and a line boundary swallows any px_en in its cycle.
        if (vs_edge) begin
          short_frame_evt = 1'b1;
          restart         = 1'b1;
          state_d         = hs_edge ? ACTIVE : ARMED;
        end else if (hs_edge) begin
          new_line       = 1'b1;
          short_line_evt = (x < X_END);
        end else if (bus.px_en) begin
          if (x >= X_END) begin
            long_px = 1'b1;
          end else if (line < L_END) begin
            accept = 1'b1;
            if (x == X_LAST && line == L_LAST) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef GBCAP_DOUBLE_BUF_EN
  logic wr_bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (state == DONE) begin
      wr_bank <= ~wr_bank;
      rd_bank <= wr_bank;
    end
  end
`else
  assign rd_bank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fb_we       <= 1'b0;
      bus.fb_addr     <= '0;
      bus.fb_data     <= '0;
      x               <= '0;
      line            <= '0;
      base            <= '0;
      frame_cnt       <= '0;
      err_short_line  <= 1'b0;
      err_long_line   <= 1'b0;
      err_short_frame <= 1'b0;
    end else begin
      bus.fb_we <= accept;
      if (accept) begin
`ifdef GBCAP_DOUBLE_BUF_EN
        bus.fb_addr <= {wr_bank, pix_addr};
`else
        bus.fb_addr <= pix_addr;
`endif
        bus.fb_data <= bus.d;
      end

      // base advances by one line width per hsync instead of line*H_PIXELS.
      if (restart) begin
        x    <= '0;
        line <= '0;
        base <= '0;
      end else if (new_line) begin
        x <= '0;
        if (line < L_END) begin
          line <= line + 8'd1;
          base <= base + H_STEP;
        end
      end else if (accept) begin
        x <= x + XW'(1);
      end

      err_short_line  <= short_line_evt  | (err_short_line  & ~clr_err);
      err_long_line   <= long_px         | (err_long_line   & ~clr_err);
      err_short_frame <= short_frame_evt | (err_short_frame & ~clr_err);

      if (state == DONE) frame_cnt <= frame_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_gb_lcd_capture.sv
// Self-checking bench for gb_lcd_capture: randomized pixels against a line/pixel
// reference model; honours GBCAP_DOUBLE_BUF_EN when it is defined.
module tb_gb_lcd_capture;
  localparam int H  = 160;
  localparam int V  = 144;
  localparam int PB = 2;
  localparam int AW = 15;
`ifdef GBCAP_DOUBLE_BUF_EN
  localparam int FB_AW = AW + 1;
`else
  localparam int FB_AW = AW;
`endif
  localparam int EW = FB_AW + PB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_err = 1'b0;
  logic       frame_done, rd_bank;
  logic [7:0] line_idx, frame_cnt;
  logic       err_short_line, err_long_line, err_short_frame;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  gb_lcd_capture_if #(.PIX_BITS(PB), .ADDR_W(AW)) bus ();

  gb_lcd_capture #(.H_PIXELS(H), .V_LINES(V), .PIX_BITS(PB), .ADDR_W(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .clr_err         (clr_err),
    .frame_done      (frame_done),
    .rd_bank         (rd_bank),
    .line_idx        (line_idx),
    .frame_cnt       (frame_cnt),
    .err_short_line  (err_short_line),
    .err_long_line   (err_long_line),
    .err_short_frame (err_short_frame),
    .dbg_state       (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  int            m_line = 0;
  int            m_x = 0;
  bit            m_bank = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bus.fb_we === 1'b1) begin
      wr_cnt++;
      last_addr = bus.fb_addr[AW-1:0];
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", bus.fb_addr, bus.fb_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.fb_addr, bus.fb_data} !== e) begin
          n_fail++;
          $display("FAIL fb_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   bus.fb_addr, bus.fb_data, e[EW-1:PB], e[PB-1:0]);
        end
      end
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      n_cmp++;
      if (!(bus.fb_we === 1'b1 && bus.fb_addr[AW-1:0] == AW'(H*V-1))) begin
        n_fail++;
        $display("FAIL frame_done_align: got we=%b addr=%0d, required we=1 addr=%0d", bus.fb_we, bus.fb_addr[AW-1:0], H*V-1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input int n);
    bus.px_en = 1'b0;
    bus.hs    = 1'b0;
    bus.vs    = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    bus.px_en = 1'b0; bus.hs = 1'b0; bus.vs = 1'b0; bus.d = '0;
    clr_err = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_line = 0; m_x = 0; m_bank = 1'b0;
  endtask

  task automatic push_exp(input logic [PB-1:0] dv);
    logic [FB_AW-1:0] a;
    a = FB_AW'(m_line * H + m_x);
`ifdef GBCAP_DOUBLE_BUF_EN
    a[FB_AW-1] = m_bank;
`endif
    exp_q.push_back({a, dv});
  endtask

  task automatic send_pixel(input bit gaps);
    logic [PB-1:0] dv;
    dv = PB'($urandom_range(0, (1 << PB) - 1));
    bus.px_en = 1'b1;
    bus.d     = dv;
    if (m_x < H && m_line < V) begin
      push_exp(dv);
      m_x++;
    end
    step();
    bus.px_en = 1'b0;
    if (gaps && $urandom_range(0, 15) == 0) step();
  endtask

  task automatic send_line(input int n, input bit gaps);
    for (int i = 0; i < n; i++) send_pixel(gaps);
  endtask

  task automatic hs_pulse();
    bus.hs = 1'b1;
    step();
    bus.hs = 1'b0;
    m_line++;
    m_x = 0;
  endtask

  task automatic frame_start();
    bus.vs = 1'b1;
    bus.hs = 1'b1;
    step();
    bus.vs = 1'b0;
    bus.hs = 1'b0;
    m_line = 0;
    m_x = 0;
  endtask

  task automatic send_frame(input bit gaps);
    frame_start();
    for (int l = 0; l < V; l++) begin
      if (l > 0) hs_pulse();
      send_line(H, gaps);
    end
    drive_idle(4);
    m_bank = ~m_bank;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b required 0", bus.fb_we); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    n_cmp++; if ({err_short_line, err_long_line, err_short_frame} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {err_short_line, err_long_line, err_short_frame}); end
    n_cmp++; if ({line_idx, frame_cnt} !== 16'h0) begin
      n_fail++; $display("FAIL reset_counters: got line=%0d frames=%0d required 0 0", line_idx, frame_cnt); end
    n_cmp++; if ({rd_bank, bus.fb_addr, bus.fb_data} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got bank=%b addr=%0h data=%0h required 0", rd_bank, bus.fb_addr, bus.fb_data); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
  endtask

  task automatic test_clean_frame();
    int wr0, dn0;
    do_reset();
    wr0 = wr_cnt; dn0 = done_cnt;
    send_frame(1'b1);
    n_cmp++; if (wr_cnt - wr0 != H*V) begin n_fail++; $display("FAIL clean_writes: got %0d required %0d", wr_cnt - wr0, H*V); end
    n_cmp++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL clean_done_pulses: got %0d required 1", done_cnt - dn0); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL clean_frame_cnt: got %0d required 1", frame_cnt); end
    n_cmp++; if ({err_short_line, err_long_line, err_short_frame} !== 3'b000) begin
      n_fail++; $display("FAIL clean_flags: got %b required 000", {err_short_line, err_long_line, err_short_frame}); end
    n_cmp++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL clean_rd_bank: got %b required 0", rd_bank); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clean_pending: got %0d left required 0", exp_q.size()); end
  endtask

  // Second clean frame straight after the first, px_en every cycle.
  task automatic test_double_buffer();
    int wr0, dn0;
    logic exp_bank;
`ifdef GBCAP_DOUBLE_BUF_EN
    exp_bank = 1'b1;
`else
    exp_bank = 1'b0;
`endif
    wr0 = wr_cnt; dn0 = done_cnt;
    send_frame(1'b0);
    n_cmp++; if (wr_cnt - wr0 != H*V) begin n_fail++; $display("FAIL b2b_writes: got %0d required %0d", wr_cnt - wr0, H*V); end
    n_cmp++; if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d required 1", done_cnt - dn0); end
    n_cmp++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt); end
    n_cmp++; if (rd_bank !== exp_bank) begin n_fail++; $display("FAIL b2b_rd_bank: got %b required %b", rd_bank, exp_bank); end
  endtask

  task automatic test_short_line();
    do_reset();
    frame_start();
    for (int l = 0; l < 6; l++) begin
      if (l > 0) hs_pulse();
      send_line((l == 5) ? 100 : H, 1'b1);
    end
    hs_pulse();
    send_line(1, 1'b0);
    drive_idle(2);
    n_cmp++; if (last_addr !== AW'(960)) begin n_fail++; $display("FAIL short_next_addr: got %0d required 960", last_addr); end
    n_cmp++; if ({err_short_line, err_long_line, err_short_frame} !== 3'b100) begin
      n_fail++; $display("FAIL short_flags: got %b required 100", {err_short_line, err_long_line, err_short_frame}); end
    n_cmp++; if (line_idx !== 8'd6) begin n_fail++; $display("FAIL short_line_idx: got %0d required 6", line_idx); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++; if (err_short_line !== 1'b0) begin n_fail++; $display("FAIL short_clear: got %b required 0", err_short_line); end
  endtask

  task automatic test_long_line();
    int wr0;
    do_reset();
    wr0 = wr_cnt;
    frame_start();
    send_line(164, 1'b0);
    clr_err = 1'b1;
    send_pixel(1'b0);
    clr_err = 1'b0;
    n_cmp++; if (err_long_line !== 1'b1) begin n_fail++; $display("FAIL long_set_beats_clear: got %b required 1", err_long_line); end
    hs_pulse();
    send_line(2, 1'b0);
    drive_idle(2);
    n_cmp++; if (wr_cnt - wr0 != 162) begin n_fail++; $display("FAIL long_writes: got %0d required 162", wr_cnt - wr0); end
    n_cmp++; if (last_addr !== AW'(161)) begin n_fail++; $display("FAIL long_next_line: got %0d required 161", last_addr); end
    n_cmp++; if ({err_short_line, err_long_line} !== 2'b01) begin
      n_fail++; $display("FAIL long_flags: got %b required 01", {err_short_line, err_long_line}); end
  endtask

  task automatic test_vs_abort();
    int dn0;
    do_reset();
    dn0 = done_cnt;
    frame_start();
    for (int l = 0; l < 71; l++) begin
      if (l > 0) hs_pulse();
      send_line((l == 70) ? 20 : H, 1'b1);
    end
    frame_start();
    send_line(5, 1'b1);
    drive_idle(2);
    n_cmp++; if (err_short_frame !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b required 1", err_short_frame); end
    n_cmp++; if (err_short_line !== 1'b0) begin n_fail++; $display("FAIL abort_short_line: got %b required 0", err_short_line); end
    n_cmp++; if (done_cnt != dn0 || frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL abort_no_done: got pulses=%0d frames=%0d required 0 0", done_cnt - dn0, frame_cnt); end
    n_cmp++; if (last_addr !== AW'(4)) begin n_fail++; $display("FAIL abort_restart_addr: got %0d required 4", last_addr); end
    n_cmp++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL abort_bank: got %b required 0", rd_bank); end
  endtask

  task automatic test_reset_mid_frame();
    int wr0;
    do_reset();
    frame_start();
    for (int l = 0; l < 41; l++) begin
      if (l > 0) hs_pulse();
      send_line((l == 39) ? 150 : ((l == 40) ? 10 : H), 1'b1);
    end
    n_cmp++; if (line_idx !== 8'd40 || err_short_line !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_reset: got line=%0d short=%b required 40 1", line_idx, err_short_line); end
    rst = 1'b1;
    bus.px_en = 1'b1;
    bus.d = PB'($urandom_range(0, (1 << PB) - 1));
    step();
    n_cmp++; if (bus.fb_we !== 1'b0) begin n_fail++; $display("FAIL mid_fb_we: got %b required 0", bus.fb_we); end
    n_cmp++; if ({err_short_line, err_long_line, err_short_frame, line_idx, frame_cnt} !== 19'h0) begin
      n_fail++; $display("FAIL mid_cleared: got flags=%b line=%0d frames=%0d required 0", {err_short_line, err_long_line, err_short_frame}, line_idx, frame_cnt); end
    rst = 1'b0;
    bus.px_en = 1'b0;
    wr0 = wr_cnt;
    bus.hs = 1'b1; step(); bus.hs = 1'b0;
    for (int i = 0; i < 5; i++) begin bus.px_en = 1'b1; step(); end
    drive_idle(2);
    n_cmp++; if (wr_cnt != wr0) begin n_fail++; $display("FAIL mid_needs_vs: got %0d writes required 0", wr_cnt - wr0); end
    frame_start();
    send_line(3, 1'b0);
    drive_idle(2);
    n_cmp++; if (last_addr !== AW'(2)) begin n_fail++; $display("FAIL mid_resume: got %0d required 2", last_addr); end
  endtask

  initial begin
    bus.hs = 1'b0; bus.vs = 1'b0; bus.px_en = 1'b0; bus.d = '0;
    test_reset();
    test_clean_frame();
    test_double_buffer();
    test_short_line();
    test_long_line();
    test_vs_abort();
    test_reset_mid_frame();
    drive_idle(2);
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_pending: got %0d left required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
